// File: rtl/rv32i_mem_pkg.sv
// Shared encodings for the RV32I unified-memory arbiter: access sizes, FSM states, grant owner.
package rv32i_mem_pkg;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_ILL = 2'b11;

    localparam int DEFAULT_TIMEOUT = 255;
    localparam int CNT_W           = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_t;

endpackage

// File: rtl/rv32i_mem_lane_align.sv
// Byte-lane steering for one access: alignment check, store enables/replication, load extract/extend.
// Purely combinational; the arbiter decides whether live or latched request fields feed it.
module rv32i_mem_lane_align
    import rv32i_mem_pkg::*;
(
    input  logic        fetch_i,
    input  logic        write_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic        err_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign ld_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        err_o   = 1'b0;
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        if (fetch_i) begin
            err_o = (addr_lo_i != 2'b00);
        end else begin
            case (size_i)
                SZ_B: begin
                    be_o    = 4'b0001 << addr_lo_i;
                    wdata_o = {4{wdata_i[7:0]}};
                    rdata_o = {{24{~unsigned_i & ld_byte[7]}}, ld_byte};
                end
                SZ_H: begin
                    err_o   = addr_lo_i[0];
                    be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                    wdata_o = {2{wdata_i[15:0]}};
                    rdata_o = {{16{~unsigned_i & ld_half[15]}}, ld_half};
                end
                SZ_W: begin
                    err_o = (addr_lo_i != 2'b00);
                end
                default: begin
                    err_o = 1'b1;
                end
            endcase
            // Loads always read the whole word; lanes only matter for writes.
            if (!write_i) begin
                be_o = 4'b1111;
            end
        end
    end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Round-robin share of one memory port between fetch and data; min latency request->ack 2 cycles, 1 for rejected requests.
// Requesters hold their level request and stall via cpu_stall until their one-cycle ack; mem_ready stretches ACCESS up to TIMEOUT.
module rv32i_mem_arbiter
    import rv32i_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    output logic              if_err,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic              d_err,
    output logic              cpu_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    gnt_t                last_q, last_d;
    gnt_t                gnt_q, gnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic                we_q, we_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                d_req;
    logic                idle;
    gnt_t                arb_gnt;
    logic                al_fetch, al_write, al_uns, al_err;
    logic [1:0]          al_size, al_addr_lo;
    logic [31:0]         al_wdata_in, al_wdata, al_rdata;
    logic [3:0]          al_be;
    logic                req_err;

    assign d_req = d_read | d_write;
    assign idle  = (state_q == IDLE);

    always_comb begin
        if (if_req && d_req) begin
            arb_gnt = (last_q == GNT_IF) ? GNT_D : GNT_IF;
        end else if (if_req) begin
            arb_gnt = GNT_IF;
        end else begin
            arb_gnt = GNT_D;
        end
    end

    // In IDLE the aligner checks the candidate request; afterwards it works from the latched copy.
    assign al_fetch    = idle ? (arb_gnt == GNT_IF) : (gnt_q == GNT_IF);
    assign al_write    = idle ? ((arb_gnt == GNT_D) & d_write) : we_q;
    assign al_size     = idle ? d_size : size_q;
    assign al_addr_lo  = idle ? ((arb_gnt == GNT_IF) ? if_addr[1:0] : d_addr[1:0]) : addr_q[1:0];
    assign al_uns      = idle ? d_unsigned : uns_q;
    assign al_wdata_in = idle ? d_wdata : wdata_q;

    rv32i_mem_lane_align u_align (
        .fetch_i    (al_fetch),
        .write_i    (al_write),
        .size_i     (al_size),
        .addr_lo_i  (al_addr_lo),
        .unsigned_i (al_uns),
        .wdata_i    (al_wdata_in),
        .rdata_i    (mem_rdata),
        .err_o      (al_err),
        .be_o       (al_be),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata)
    );

    assign req_err = al_err | ((arb_gnt == GNT_D) & d_read & d_write);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= GNT_D;
            gnt_q   <= GNT_IF;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    last_d  = arb_gnt;
                    gnt_d   = arb_gnt;
                    addr_d  = (arb_gnt == GNT_IF) ? if_addr : d_addr;
                    wdata_d = d_wdata;
                    size_d  = d_size;
                    uns_d   = d_unsigned;
                    we_d    = (arb_gnt == GNT_D) & d_write;
                    cnt_d   = '0;
                    rdata_d = '0;
                    err_d   = req_err;
                    state_d = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    rdata_d = (gnt_q == GNT_IF) ? mem_rdata : al_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_req   = (state_q == ACCESS);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_be    = mem_req ? al_be : 4'b0000;
    assign mem_wdata = mem_we ? al_wdata : 32'h0;

    assign if_ack   = (state_q == RESP) & (gnt_q == GNT_IF);
    assign d_ack    = (state_q == RESP) & (gnt_q == GNT_D);
    assign if_err   = if_ack & err_q;
    assign d_err    = d_ack & err_q;
    assign if_rdata = if_ack ? rdata_q : 32'h0;
    assign d_rdata  = d_ack ? rdata_q : 32'h0;

    assign cpu_stall = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter with a short TIMEOUT so the bus-error path is quick to reach.
module tb_rv32i_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack, if_err;
    logic        d_read, d_write;
    logic [31:0] d_addr, d_wdata;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [31:0] d_rdata;
    logic        d_ack, d_err;
    logic        cpu_stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    rv32i_mem_arbiter #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ack     (if_ack),
        .if_err     (if_err),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_size     (d_size),
        .d_unsigned (d_unsigned),
        .d_rdata    (d_rdata),
        .d_ack      (d_ack),
        .d_err      (d_err),
        .cpu_stall  (cpu_stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        if_req     = 1'b0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_unsigned = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        d_size = 2'b00; d_unsigned = 1'b0;
        mem_rdata = '0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_acks", {30'b0, if_ack, d_ack}, 32'd0);
        chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
        chk("rst_be", {28'b0, mem_be}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Fetch alone, memory always ready.
        if_req = 1'b1; if_addr = 32'h40; mem_ready = 1'b1; mem_rdata = 32'h0010_0093;
        #1;
        chk("fetch_stall_c0", {31'b0, cpu_stall}, 32'd1);
        tick();
        chk("fetch_req_c1", {31'b0, mem_req}, 32'd1);
        chk("fetch_addr", mem_addr, 32'h40);
        chk("fetch_be", {28'b0, mem_be}, 32'hF);
        chk("fetch_we", {31'b0, mem_we}, 32'd0);
        chk("fetch_noack_c1", {31'b0, if_ack}, 32'd0);
        tick();
        chk("fetch_ack_c2", {31'b0, if_ack}, 32'd1);
        chk("fetch_rdata", if_rdata, 32'h0010_0093);
        chk("fetch_err", {31'b0, if_err}, 32'd0);
        chk("fetch_req_c2", {31'b0, mem_req}, 32'd0);
        chk("fetch_stall_c2", {31'b0, cpu_stall}, 32'd0);
        idle_inputs();
        tick();
        chk("fetch_ack_once", {31'b0, if_ack}, 32'd0);

        // Byte store to the top lane.
        d_write = 1'b1; d_addr = 32'h103; d_size = 2'b00; d_wdata = 32'h0000_00AB;
        tick();
        chk("sb_addr", mem_addr, 32'h100);
        chk("sb_be", {28'b0, mem_be}, 32'b1000);
        chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        chk("sb_we", {31'b0, mem_we}, 32'd1);
        tick();
        chk("sb_ack", {30'b0, d_ack, d_err}, 32'b10);
        idle_inputs();
        tick();
        chk("sb_ack_once", {31'b0, d_ack}, 32'd0);

        // Half store to the upper half.
        d_write = 1'b1; d_addr = 32'h202; d_size = 2'b01; d_wdata = 32'hDEAD_1234;
        tick();
        chk("sh_be", {28'b0, mem_be}, 32'b1100);
        chk("sh_wdata", mem_wdata, 32'h1234_1234);
        chk("sh_addr", mem_addr, 32'h200);
        tick();
        chk("sh_ack", {31'b0, d_ack}, 32'd1);
        idle_inputs();
        tick();

        // Loads from word 0x8001_1234.
        mem_rdata = 32'h8001_1234;
        d_read = 1'b1; d_addr = 32'h102; d_size = 2'b01; d_unsigned = 1'b0;
        tick();
        chk("lh_be", {28'b0, mem_be}, 32'hF);
        chk("lh_we", {31'b0, mem_we}, 32'd0);
        tick();
        chk("lh_rdata", d_rdata, 32'hFFFF_8001);
        idle_inputs();
        tick();
        d_read = 1'b1; d_addr = 32'h102; d_size = 2'b01; d_unsigned = 1'b1;
        tick(); tick();
        chk("lhu_rdata", d_rdata, 32'h0000_8001);
        idle_inputs();
        tick();
        d_read = 1'b1; d_addr = 32'h101; d_size = 2'b00; d_unsigned = 1'b0;
        tick(); tick();
        chk("lb_rdata", d_rdata, 32'h0000_0012);
        idle_inputs();
        tick();
        d_read = 1'b1; d_addr = 32'h103; d_size = 2'b00; d_unsigned = 1'b0;
        tick(); tick();
        chk("lb_sign", d_rdata, 32'hFFFF_FF80);
        idle_inputs();
        tick();
        d_read = 1'b1; d_addr = 32'h100; d_size = 2'b10;
        tick();
        d_addr = 32'h7FC; d_size = 2'b00;
        tick();
        chk("lw_latched", d_rdata, 32'h8001_1234);
        idle_inputs();
        tick();

        // Rejected requests: ack+err one cycle after request, no memory access.
        d_read = 1'b1; d_addr = 32'h102; d_size = 2'b10;
        tick();
        chk("lw_mis_ack", {30'b0, d_ack, d_err}, 32'b11);
        chk("lw_mis_noreq", {31'b0, mem_req}, 32'd0);
        idle_inputs();
        tick();
        d_read = 1'b1; d_addr = 32'h100; d_size = 2'b11;
        tick();
        chk("ill_size_ack", {30'b0, d_ack, d_err}, 32'b11);
        chk("ill_size_noreq", {31'b0, mem_req}, 32'd0);
        idle_inputs();
        tick();
        d_read = 1'b1; d_write = 1'b1; d_addr = 32'h100; d_size = 2'b10;
        tick();
        chk("rw_both_ack", {30'b0, d_ack, d_err}, 32'b11);
        idle_inputs();
        tick();
        if_req = 1'b1; if_addr = 32'h42;
        tick();
        chk("if_mis_ack", {30'b0, if_ack, if_err}, 32'b11);
        chk("if_mis_noreq", {31'b0, mem_req}, 32'd0);
        idle_inputs();
        tick();

        // Timeout: memory never ready.
        mem_ready = 1'b0; mem_rdata = 32'h1234_5678;
        d_read = 1'b1; d_addr = 32'h100; d_size = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("to_req_%0d", i), {30'b0, mem_req, d_ack}, 32'b10);
        end
        tick();
        chk("to_req_drop", {31'b0, mem_req}, 32'd0);
        chk("to_ack_err", {30'b0, d_ack, d_err}, 32'b11);
        chk("to_rdata", d_rdata, 32'h0);
        idle_inputs();
        tick();

        // Reset in the middle of a data access, with fetch pending on release.
        d_read = 1'b1; d_addr = 32'h100; d_size = 2'b10;
        tick();
        chk("mid_req", {31'b0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'b0, mem_req}, 32'd0);
        chk("mid_rst_acks", {30'b0, if_ack, d_ack}, 32'd0);
        if_req = 1'b1; if_addr = 32'h80; mem_ready = 1'b1; mem_rdata = 32'h0010_0093;
        tick();
        rst_n = 1'b1;
        // Both requesters held: fetch first, then strict alternation every 3 cycles.
        for (int i = 1; i <= 9; i++) begin
            int  phase;
            bit  fetch_turn;
            tick();
            phase      = (i - 1) % 3;
            fetch_turn = (((i - 1) / 3) % 2) == 0;
            if (phase == 0) begin
                chk($sformatf("rr_addr_%0d", i), mem_addr, fetch_turn ? 32'h80 : 32'h100);
            end else if (phase == 1) begin
                chk($sformatf("rr_ack_%0d", i), {30'b0, if_ack, d_ack},
                    fetch_turn ? 32'b10 : 32'b01);
            end
        end
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32i_mem_arbiter.md
Name: rv32i_mem_arbiter

Overview:
- Shares one single-ported unified memory between the RV32I core's instruction-fetch port (pc/instr) and its data port (MemAddr/dataOut/dataIn/MemRead/MemWrite/addMemControl).
- Performs round-robin arbitration, byte-lane steering, load sign/zero extension, misalignment checking and a ready-timeout.
- Sits between the core and the memory model/SRAM wrapper.
- Drives the core's stall so multi-cycle memory is transparent.

Parameters:
- ADDR_W, 32, address width (data fixed at 32).
- TIMEOUT, 255, max cycles waiting for mem_ready before bus error (1..65535).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, level, held until if_ack
- if_addr  in  ADDR_W  fetch address (pc)
- if_rdata  out  32  fetched instruction, valid with if_ack
- if_ack  out  1  one-cycle completion pulse
- if_err  out  1  with if_ack: misaligned or timeout
- d_read  in  1  load request (MemRead), level
- d_write  in  1  store request (MemWrite), level
- d_addr  in  ADDR_W  byte address (MemAddr)
- d_wdata  in  32  store data (dataOut)
- d_size  in  2  addMemControl: 00 byte, 01 half, 10 word, 11 illegal
- d_unsigned  in  1  load zero-extend (funct3[2])
- d_rdata  out  32  aligned, extended load data (dataIn), valid with d_ack
- d_ack  out  1  one-cycle completion pulse
- d_err  out  1  with d_ack: misaligned/illegal/timeout
- cpu_stall  out  1  (if_req & ~if_ack) | ((d_read|d_write) & ~d_ack), combinational
- mem_req  out  1  memory request, registered
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  word-aligned address ([1:0]=00)
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated write data
- mem_rdata  in  32  read word, valid when mem_ready
- mem_ready  in  1  completes access in the cycle it is high with mem_req

Behaviour:
- Reset (async, rst_n=0): state IDLE, all outputs 0, last_grant=DATA (fetch wins first tie), timeout counter 0. Reset mid-access abandons it; mem_req drops immediately.
- States:
  - IDLE: arbitrate, latch request.
  - ACCESS: mem_req=1.
  - RESP: ack pulse.
- IDLE arbitration:
  - Only one requester active: grant it.
  - Both active: grant the one not in last_grant.
  - On grant, update last_grant and latch addr/wdata/size/unsigned/we.
- Illegal request goes IDLE->RESP with err=1 and no mem_req:
  - d_read & d_write both high;
  - d_size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - fetch with addr[1:0]!=0.
- Legal request: IDLE->ACCESS.
  - mem_req=1 from the next cycle; mem_addr={addr[31:2],2'b00}.
  - Counter increments each cycle mem_ready=0.
  - mem_ready=1: capture mem_rdata, go to RESP.
  - Counter reaches TIMEOUT: drop mem_req, go to RESP with err=1, rdata=0.
- RESP: the granted ack is high for exactly one cycle, together with rdata/err, then IDLE. Requests are not sampled in RESP, so a requester drops its request in the cycle after ack. Minimum latency is request at cycle 0, mem_req at cycle 1, ready at cycle 1, ack at cycle 2.
- Store lanes:
  - Byte: be=1<<addr[1:0], wdata={4{b}}.
  - Half: be=addr[1]?1100:0011, wdata={2{h}}.
  - Word: be=1111.
- Loads and fetch drive be=1111 and mem_we=0.
- Load extract:
  - Byte: lane addr[1:0].
  - Half: lane addr[1].
  - Sign-extended unless d_unsigned; word passes through.
- Request inputs changing while not IDLE are ignored; latched values are used.

Decomposition:
- Package rv32i_mem_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_ILL;
  - state enum IDLE/ACCESS/RESP;
  - grant enum GNT_IF/GNT_D;
  - default TIMEOUT.
- Sub-module rv32i_mem_lane_align (combinational) handles misalignment detect, store be/wdata replication and load extract/extend. The arbiter keeps the FSM, counter and registers.

Test Plan:
- Fetch only: if_addr=0x40, mem_ready tied 1, mem_rdata=0x00100093 -> mem_req cycle 1, if_ack cycle 2 with if_rdata=0x00100093, if_err=0, be=1111.
- Store byte: d_write, d_addr=0x103, d_size=00, d_wdata=0xAB -> mem_addr=0x100, be=1000, wdata=0xABABABAB, mem_we=1, d_ack one pulse.
- Loads:
  - Signed half: d_addr=0x102, d_size=01, mem_rdata=0x8001_1234 -> d_rdata=0xFFFF8001.
  - d_unsigned=1 -> 0x00008001.
  - Byte at 0x101 -> 0x00000012.
- Contention: if_req and d_read held together from reset, ready always 1 -> fetch served first, then data, alternating; neither waits more than one transaction.
- Errors:
  - Word load at 0x102 -> d_ack+d_err at cycle 1, no mem_req.
  - d_size=11 -> same.
  - mem_ready held 0, TIMEOUT=4 -> mem_req for 4 cycles, then ack+err, rdata=0.
- Reset mid-access: rst_n=0 during ACCESS -> mem_req, acks and cpu_stall-related state clear immediately; after release, a pending if_req is granted first.
